// File: rtl/deser_stream_if.sv
// Serial-in / word-out bundle for deser_stream.
// The slave modport is the deserializer's view; the master modport is the front end and consumer side.
interface deser_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) ();
  logic              data_i;
  logic              data_val_i;
  logic              data_last_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [CNT_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              deser_data_ready_i;
  logic              deser_ovf_o;

  modport slave (
    input  data_i, data_val_i, data_last_i, deser_data_ready_i,
    output deser_data_o, deser_mod_o, deser_data_val_o, deser_ovf_o
  );

  modport master (
    output data_i, data_val_i, data_last_i, deser_data_ready_i,
    input  deser_data_o, deser_mod_o, deser_data_val_o, deser_ovf_o
  );
endinterface

// File: rtl/deser_stream.sv
// Serial-to-parallel converter with selectable bit order, early termination,
// and a registered valid/ready output stage that reports dropped words.
module deser_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  deser_stream_if.slave      bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [CNT_W-1:0]  pend_mod_q, pend_mod_d;
  logic              pend_val_q, pend_val_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_mod_q, out_mod_d;
  logic              out_val_q, out_val_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  bit_pos;
  logic              complete;

  // Each bit is written straight to its full-word position, so a partial word
  // is already aligned when it completes and unreceived positions stay 0.
  always_comb begin
    bit_pos = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;
    word    = sr_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (CNT_W'(i) == bit_pos) word[i] = bus.data_i;
    end
    complete = bus.data_val_i && (bus.data_last_i || (cnt_q == CNT_LAST));

    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bus.data_val_i) begin
      if (complete) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = word;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    pend_val_d  = complete;
    pend_data_d = word;
    pend_mod_d  = cnt_q + CNT_W'(1);
  end

  // The pending register gives the one-cycle latency; the output stage decides
  // load / drop / clear against ready on the following edge.
  always_comb begin
    out_data_d = out_data_q;
    out_mod_d  = out_mod_q;
    out_val_d  = out_val_q;
    ovf_d      = 1'b0;
    if (pend_val_q) begin
      if (!out_val_q || bus.deser_data_ready_i) begin
        out_data_d = pend_data_q;
        out_mod_d  = pend_mod_q;
        out_val_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_val_q && bus.deser_data_ready_i) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_data_q <= '0;
      pend_mod_q  <= '0;
      pend_val_q  <= 1'b0;
      out_data_q  <= '0;
      out_mod_q   <= '0;
      out_val_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      pend_data_q <= pend_data_d;
      pend_mod_q  <= pend_mod_d;
      pend_val_q  <= pend_val_d;
      out_data_q  <= out_data_d;
      out_mod_q   <= out_mod_d;
      out_val_q   <= out_val_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.deser_data_o     = out_data_q;
  assign bus.deser_mod_o      = out_mod_q;
  assign bus.deser_data_val_o = out_val_q;
  assign bus.deser_ovf_o      = ovf_q;

endmodule

// File: tb/tb_deser_stream.sv
// Directed bench for deser_stream: three instances (16/MSB, 16/LSB, 8/LSB) share one serial stream.
module tb_deser_stream;

  logic clk;
  logic srst_n, din, dval, dlast, rdy;
  int   checks;
  int   errors;

  deser_stream_if #(.DATA_W(16)) if_a ();
  deser_stream_if #(.DATA_W(16)) if_b ();
  deser_stream_if #(.DATA_W(8))  if_c ();

  assign if_a.data_i = din;  assign if_a.data_val_i = dval;
  assign if_a.data_last_i = dlast;  assign if_a.deser_data_ready_i = rdy;
  assign if_b.data_i = din;  assign if_b.data_val_i = dval;
  assign if_b.data_last_i = dlast;  assign if_b.deser_data_ready_i = rdy;
  assign if_c.data_i = din;  assign if_c.data_val_i = dval;
  assign if_c.data_last_i = dlast;  assign if_c.deser_data_ready_i = rdy;

  deser_stream #(.DATA_W(16), .MSB_FIRST(1)) u_a (.clk_i(clk), .srst_n_i(srst_n), .bus(if_a.slave));
  deser_stream #(.DATA_W(16), .MSB_FIRST(0)) u_b (.clk_i(clk), .srst_n_i(srst_n), .bus(if_b.slave));
  deser_stream #(.DATA_W(8),  .MSB_FIRST(0)) u_c (.clk_i(clk), .srst_n_i(srst_n), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic l);
    din = b; dval = 1'b1; dlast = l;
    tick();
    din = 1'b0; dval = 1'b0; dlast = 1'b0;
  endtask

  task automatic idle();
    dval = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  task automatic send16(input logic [15:0] w);
    for (int k = 0; k < 16; k++) send_bit(w[15-k], 1'b0);
  endtask

  task automatic test_reset();
    srst_n = 1'b0; din = 1'b0; dval = 1'b0; dlast = 1'b0; rdy = 1'b1;
    tick(); tick();
    checks++; if (if_a.deser_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", if_a.deser_data_o); end
    checks++; if (if_a.deser_mod_o !== 5'd0) begin errors++; $display("FAIL reset_mod: got %0d expected 0", if_a.deser_mod_o); end
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", if_a.deser_ovf_o); end
    checks++; if (if_c.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL reset_val_c: got %b expected 0", if_c.deser_data_val_o); end
    srst_n = 1'b1;
  endtask

  task automatic test_full_word();
    logic [15:0] w;
    w = 16'hA5C3;
    rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send_bit(w[15-k], 1'b0);
      if ((k % 3) == 2 && k < 15) idle();
    end
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL full_early_val: got %b expected 0", if_a.deser_data_val_o); end
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL full_val: got %b expected 1", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_data_o !== 16'hA5C3) begin errors++; $display("FAIL full_data: got %h expected a5c3", if_a.deser_data_o); end
    checks++; if (if_a.deser_mod_o !== 5'd16) begin errors++; $display("FAIL full_mod: got %0d expected 16", if_a.deser_mod_o); end
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL full_single_pulse: got %b expected 0", if_a.deser_data_val_o); end
  endtask

  task automatic test_partial();
    logic [4:0] pb;
    pb = 5'b10110;
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) send_bit(pb[4-k], k == 4);
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL partial_val_msb: got %b expected 1", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_data_o !== 16'hB000) begin errors++; $display("FAIL partial_data_msb: got %h expected b000", if_a.deser_data_o); end
    checks++; if (if_a.deser_mod_o !== 5'd5) begin errors++; $display("FAIL partial_mod_msb: got %0d expected 5", if_a.deser_mod_o); end
    checks++; if (if_b.deser_data_o !== 16'h000D) begin errors++; $display("FAIL partial_data_lsb: got %h expected 000d", if_b.deser_data_o); end
    checks++; if (if_b.deser_mod_o !== 5'd5) begin errors++; $display("FAIL partial_mod_lsb: got %0d expected 5", if_b.deser_mod_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2;
    w1 = 8'h3C; w2 = 8'h81;
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) send_bit(w1[k], 1'b0);
    for (int k = 0; k < 8; k++) begin
      send_bit(w2[k], k == 7);
      if (k == 0) begin
        checks++; if (if_c.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL b2b_val1: got %b expected 1", if_c.deser_data_val_o); end
        checks++; if (if_c.deser_data_o !== 8'h3C) begin errors++; $display("FAIL b2b_data1: got %h expected 3c", if_c.deser_data_o); end
        checks++; if (if_c.deser_mod_o !== 4'd8) begin errors++; $display("FAIL b2b_mod1: got %0d expected 8", if_c.deser_mod_o); end
      end else begin
        checks++; if (if_c.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL b2b_gap_val k=%0d: got %b expected 0", k, if_c.deser_data_val_o); end
      end
    end
    idle();
    checks++; if (if_c.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL b2b_val2: got %b expected 1", if_c.deser_data_val_o); end
    checks++; if (if_c.deser_data_o !== 8'h81) begin errors++; $display("FAIL b2b_data2: got %h expected 81", if_c.deser_data_o); end
    checks++; if (if_c.deser_mod_o !== 4'd8) begin errors++; $display("FAIL b2b_mod2: got %0d expected 8", if_c.deser_mod_o); end
    idle();
    checks++; if (if_c.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL b2b_no_extra: got %b expected 0", if_c.deser_data_val_o); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w2;
    w2 = 16'h2468;
    do_reset();
    rdy = 1'b0;
    send16(16'h1357);
    send_bit(w2[15], 1'b0);
    checks++; if (if_a.deser_data_o !== 16'h1357) begin errors++; $display("FAIL bp_first_data: got %h expected 1357", if_a.deser_data_o); end
    for (int k = 1; k < 16; k++) send_bit(w2[15-k], 1'b0);
    checks++; if (if_a.deser_ovf_o !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %b expected 0", if_a.deser_ovf_o); end
    idle();
    checks++; if (if_a.deser_ovf_o !== 1'b1) begin errors++; $display("FAIL bp_ovf_pulse: got %b expected 1", if_a.deser_ovf_o); end
    checks++; if (if_a.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL bp_val_held: got %b expected 1", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_data_o !== 16'h1357) begin errors++; $display("FAIL bp_data_held: got %h expected 1357", if_a.deser_data_o); end
    idle();
    checks++; if (if_a.deser_ovf_o !== 1'b0) begin errors++; $display("FAIL bp_ovf_one_cycle: got %b expected 0", if_a.deser_ovf_o); end
    checks++; if (if_a.deser_data_o !== 16'h1357) begin errors++; $display("FAIL bp_data_stable: got %h expected 1357", if_a.deser_data_o); end
    rdy = 1'b1;
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL bp_transfer: got %b expected 0", if_a.deser_data_val_o); end
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got %b expected 0", if_a.deser_data_val_o); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w;
    w = 16'h1234;
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 9; k++) send_bit(1'b1, 1'b0);
    srst_n = 1'b0; din = 1'b1; dval = 1'b1; dlast = 1'b1;
    tick();
    srst_n = 1'b1; din = 1'b0; dval = 1'b0; dlast = 1'b0;
    checks++; if (if_a.deser_data_o !== 16'h0000) begin errors++; $display("FAIL mid_rst_data: got %h expected 0000", if_a.deser_data_o); end
    checks++; if (if_a.deser_mod_o !== 5'd0) begin errors++; $display("FAIL mid_rst_mod: got %0d expected 0", if_a.deser_mod_o); end
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL mid_rst_val: got %b expected 0", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_ovf_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: got %b expected 0", if_a.deser_ovf_o); end
    for (int k = 0; k < 16; k++) begin
      send_bit(w[15-k], 1'b0);
      checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL mid_rst_no_word k=%0d: got %b expected 0", k, if_a.deser_data_val_o); end
    end
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL mid_rst_word_val: got %b expected 1", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_data_o !== 16'h1234) begin errors++; $display("FAIL mid_rst_word_data: got %h expected 1234", if_a.deser_data_o); end
    checks++; if (if_a.deser_mod_o !== 5'd16) begin errors++; $display("FAIL mid_rst_word_mod: got %0d expected 16", if_a.deser_mod_o); end
  endtask

  task automatic test_accept_and_complete();
    do_reset();
    rdy = 1'b0;
    send16(16'h0F0F);
    send16(16'hF0F0);
    checks++; if (if_a.deser_data_o !== 16'h0F0F) begin errors++; $display("FAIL ac_old_data: got %h expected 0f0f", if_a.deser_data_o); end
    rdy = 1'b1;
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b1) begin errors++; $display("FAIL ac_val_stays: got %b expected 1", if_a.deser_data_val_o); end
    checks++; if (if_a.deser_data_o !== 16'hF0F0) begin errors++; $display("FAIL ac_new_data: got %h expected f0f0", if_a.deser_data_o); end
    checks++; if (if_a.deser_ovf_o !== 1'b0) begin errors++; $display("FAIL ac_no_ovf: got %b expected 0", if_a.deser_ovf_o); end
    idle();
    checks++; if (if_a.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL ac_drain: got %b expected 0", if_a.deser_data_val_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_accept_and_complete();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
